alphamission_front_sprite_fetch: RTL and testbench

ALPHAMISSION_FRONT_SPRITE_FETCH -- requirements
Module: alphamission_front_sprite_fetch

---
 rtl/alphamission_front_sprite_fetch_pkg.sv | 14 +
 rtl/alphamission_spr_shifter.sv | 32 +++
 rtl/alphamission_front_sprite_fetch.sv | 146 ++++++++++++++
 tb/tb_alphamission_front_sprite_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alphamission_front_sprite_fetch_pkg.sv
// alphamission_front_sprite_fetch_pkg: FSM states, attribute field offsets and pixel/line-buffer constants
package alphamission_front_sprite_fetch_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ATTR_RD, S_ATTR_CHK, S_GFX_FETCH, S_LOAD, S_PIXELS, S_NEXT, S_DONE
  } state_t;
  localparam int ATTR_Y     = 0;
  localparam int ATTR_X     = 9;
  localparam int ATTR_TILE  = 18;
  localparam int ATTR_FLIPX = 26;
  localparam int ATTR_FLIPY = 27;
  localparam int ATTR_PAL   = 28;
  localparam logic [2:0] PIX_TRANSPARENT = 3'b111;
  localparam logic [7:0] FD_IDLE = 8'hFF;
endpackage

// File: rtl/alphamission_spr_shifter.sv
// alphamission_spr_shifter: three-plane 8-pixel shifter, MSB first; horizontal flip under ALPHAMISSION_SPR_FLIP_EN
module alphamission_spr_shifter
  import alphamission_front_sprite_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [23:0] data,
`ifdef ALPHAMISSION_SPR_FLIP_EN
  input  logic        flip_x,
`endif
  output logic [2:0]  pix
);
  logic [7:0]  p2, p1, p0;
  logic [23:0] planes;
`ifdef ALPHAMISSION_SPR_FLIP_EN
  logic [7:0] r2, r1, r0;
  assign r2 = {<<{data[23:16]}};
  assign r1 = {<<{data[15:8]}};
  assign r0 = {<<{data[7:0]}};
  // Reversing the planes at load lets the shift-out path stay MSB-first for both orientations
  assign planes = flip_x ? {r2, r1, r0} : data;
`else
  assign planes = data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {p2, p1, p0} <= {{8{PIX_TRANSPARENT[2]}}, {8{PIX_TRANSPARENT[1]}}, {8{PIX_TRANSPARENT[0]}}};
    else if (load) {p2, p1, p0} <= planes;
    else if (shift) {p2, p1, p0} <= {p2[6:0], 1'b1, p1[6:0], 1'b1, p0[6:0], 1'b1};
  assign pix = {p2[7], p1[7], p0[7]};
endmodule

// File: rtl/alphamission_front_sprite_fetch.sv
// alphamission_front_sprite_fetch: per-line sprite attribute scan, graphics ROM fetch and line-buffer pixel output
// Optional horizontal/vertical flip enabled by defining ALPHAMISSION_SPR_FLIP_EN.
module alphamission_front_sprite_fetch
  import alphamission_front_sprite_fetch_pkg::*;
#(
  parameter int NSPR   = 64,
  parameter int GFX_AW = 16
) (
  input  logic                    clk,
  input  logic                    VIDEO_RSTn,
  input  logic                    CK0,
  input  logic                    LINE_START,
  input  logic [8:0]              VPOS,
  output logic [$clog2(NSPR)-1:0] ATTR_ADDR,
  input  logic [31:0]             ATTR_DATA,
  output logic                    GFX_REQ,
  output logic [GFX_AW-1:0]       GFX_ADDR,
  input  logic                    GFX_ACK,
  input  logic [23:0]             GFX_DATA,
  output logic [7:0]              FD,
  output logic [8:0]              FL_Y,
  output logic                    FCK,
  output logic                    LD,
  output logic                    LINE_DONE
);
  localparam int IW = $clog2(NSPR);
  state_t        state;
  logic [IW-1:0] idx;
  logic          half;
  logic [2:0]    cnt;
  logic [8:0]    x;
  logic [7:0]    tile;
  logic [3:0]    pal, row, erow;
  logic [8:0]    diff;
  logic          hit, load, shift;
  logic [2:0]    pix;
  assign diff  = VPOS - ATTR_DATA[ATTR_Y +: 9];
  assign hit   = diff[8:4] == 5'd0;
  assign load  = state == S_GFX_FETCH && GFX_REQ && GFX_ACK;
  assign shift = state == S_PIXELS && CK0;
`ifdef ALPHAMISSION_SPR_FLIP_EN
  logic xflip;
  assign erow = ATTR_DATA[ATTR_FLIPY] ? 4'd15 - diff[3:0] : diff[3:0];
  always_ff @(posedge clk or negedge VIDEO_RSTn)
    if (!VIDEO_RSTn) xflip <= 1'b0;
    else if (state == S_ATTR_CHK) xflip <= ATTR_DATA[ATTR_FLIPX];
`else
  logic unused_flip;
  assign unused_flip = ^ATTR_DATA[ATTR_FLIPY:ATTR_FLIPX];
  assign erow = diff[3:0];
`endif
  always_ff @(posedge clk or negedge VIDEO_RSTn)
    if (!VIDEO_RSTn) begin
      state     <= S_IDLE;
      idx       <= '0;
      half      <= 1'b0;
      cnt       <= 3'd0;
      x         <= 9'd0;
      tile      <= 8'd0;
      pal       <= 4'd0;
      row       <= 4'd0;
      ATTR_ADDR <= '0;
      GFX_REQ   <= 1'b0;
      GFX_ADDR  <= '0;
      FD        <= FD_IDLE;
      FL_Y      <= 9'd0;
      FCK       <= 1'b0;
      LD        <= 1'b1;
      LINE_DONE <= 1'b0;
    end else begin
      FD        <= FD_IDLE;
      FCK       <= 1'b0;
      LD        <= 1'b1;
      LINE_DONE <= 1'b0;
      // A new line strobe always wins and restarts the scan from entry 0
      if (LINE_START && state != S_IDLE) begin
        state     <= S_ATTR_RD;
        idx       <= '0;
        ATTR_ADDR <= '0;
        GFX_REQ   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (LINE_START) begin
            state     <= S_ATTR_RD;
            idx       <= '0;
            ATTR_ADDR <= '0;
          end
          S_ATTR_RD: state <= S_ATTR_CHK;
          S_ATTR_CHK: begin
            x    <= ATTR_DATA[ATTR_X +: 9];
            tile <= ATTR_DATA[ATTR_TILE +: 8];
            pal  <= ATTR_DATA[ATTR_PAL +: 4];
            row  <= erow;
            half <= 1'b0;
            if (hit) begin
              GFX_REQ  <= 1'b1;
              GFX_ADDR <= GFX_AW'({ATTR_DATA[ATTR_TILE +: 8], erow, 1'b0});
            end
            state <= hit ? S_GFX_FETCH : S_NEXT;
          end
          S_GFX_FETCH: if (GFX_ACK) begin
            GFX_REQ <= 1'b0;
            state   <= S_LOAD;
          end
          S_LOAD: if (CK0) begin
            FCK   <= 1'b1;
            LD    <= 1'b0;
            FL_Y  <= x + {5'd0, half, 3'd0};
            cnt   <= 3'd0;
            state <= S_PIXELS;
          end
          S_PIXELS: if (CK0) begin
            FD  <= {1'b0, pal, pix};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (!half) begin
                half     <= 1'b1;
                GFX_REQ  <= 1'b1;
                GFX_ADDR <= GFX_AW'({tile, row, 1'b1});
              end
              state <= half ? S_NEXT : S_GFX_FETCH;
            end
          end
          S_NEXT: begin
            idx       <= idx + 1'b1;
            ATTR_ADDR <= idx + 1'b1;
            LINE_DONE <= &idx;
            state     <= &idx ? S_DONE : S_ATTR_RD;
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  alphamission_spr_shifter u_shifter (
    .clk    (clk),
    .rst_n  (VIDEO_RSTn),
    .load   (load),
    .shift  (shift),
    .data   (GFX_DATA),
`ifdef ALPHAMISSION_SPR_FLIP_EN
    .flip_x (xflip),
`endif
    .pix    (pix)
  );
endmodule

// File: tb/tb_alphamission_front_sprite_fetch.sv
// tb_alphamission_front_sprite_fetch: directed vector table plus hand sequences for ack delay, abort and reset
module tb_alphamission_front_sprite_fetch;
  logic        clk = 1'b0, VIDEO_RSTn = 1'b0, CK0 = 1'b1, LINE_START = 1'b0;
  logic [8:0]  VPOS = 9'd0;
  logic [5:0]  ATTR_ADDR;
  logic [31:0] ATTR_DATA = 32'd0;
  logic        GFX_REQ, GFX_ACK = 1'b0;
  logic [15:0] GFX_ADDR;
  logic [23:0] GFX_DATA = 24'd0;
  logic [7:0]  FD;
  logic [8:0]  FL_Y;
  logic        FCK, LD, LINE_DONE;

  alphamission_front_sprite_fetch #(.NSPR(64), .GFX_AW(16)) dut (
    .clk(clk), .VIDEO_RSTn(VIDEO_RSTn), .CK0(CK0), .LINE_START(LINE_START), .VPOS(VPOS),
    .ATTR_ADDR(ATTR_ADDR), .ATTR_DATA(ATTR_DATA), .GFX_REQ(GFX_REQ), .GFX_ADDR(GFX_ADDR),
    .GFX_ACK(GFX_ACK), .GFX_DATA(GFX_DATA), .FD(FD), .FL_Y(FL_Y), .FCK(FCK), .LD(LD),
    .LINE_DONE(LINE_DONE)
  );

  initial forever #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) ATTR_DATA <= mem[ATTR_ADDR];

  int total = 0, bad = 0;
  int ack_delay = 0, wcnt = 0, req_len = 0;
  logic [23:0] gfx_val = 24'd0;
  bit ck_div = 1'b0;
  logic req_q = 1'b0;
  logic [15:0] addr_q = 16'd0;
  logic [15:0] addrs[$];
  logic [8:0]  flys[$];
  logic [7:0]  pix[$];
  int lens[$];
  int addr_moves = 0, fck_wait = 0, fck_cnt = 0, done_cnt = 0, fd_bad = 0, ld_bad = 0;

  // Observer and ROM responder share one process so sampling precedes the next drive
  initial forever begin
    @(negedge clk);
    if (GFX_REQ && !req_q) begin addrs.push_back(GFX_ADDR); req_len = 0; end
    if (GFX_REQ) begin
      req_len++;
      if (req_q && GFX_ADDR != addr_q) addr_moves++;
      if (FCK) fck_wait++;
    end else if (req_q) lens.push_back(req_len);
    if (FCK) begin flys.push_back(FL_Y); fck_cnt++; end
    if (!FD[7]) pix.push_back(FD);
    else if (FD != 8'hFF) fd_bad++;
    if (LD == FCK) ld_bad++;
    if (LINE_DONE) done_cnt++;
    req_q = GFX_REQ;
    addr_q = GFX_ADDR;
    if (GFX_REQ && wcnt == ack_delay) begin GFX_ACK = 1'b1; GFX_DATA = gfx_val; wcnt = 0; end
    else if (GFX_REQ) begin GFX_ACK = 1'b0; wcnt++; end
    else begin GFX_ACK = 1'b0; wcnt = 0; end
    CK0 = ck_div ? ~CK0 : 1'b1;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_attr(input logic [8:0] y, input logic [8:0] x, input logic [7:0] tile,
                                          input bit fx, input bit fy, input logic [3:0] pal);
    return {pal, fy, fx, tile, x, y};
  endfunction

  task automatic fill_miss(input logic [8:0] vpos);
    for (int i = 0; i < 64; i++) mem[i] = mk_attr(vpos + 9'd100, 9'd0, 8'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic clear();
    addrs.delete(); flys.delete(); pix.delete(); lens.delete();
    addr_moves = 0; fck_wait = 0; fck_cnt = 0; done_cnt = 0;
  endtask

  task automatic start_line(input logic [8:0] vpos);
    VPOS = vpos;
    LINE_START = 1'b1;
    @(negedge clk);
    LINE_START = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!LINE_DONE && lat < 6000) begin @(negedge clk); lat++; end
    chk("line_done_seen", LINE_DONE, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_pix(input int n, input string nm);
    int c = 0;
    while (pix.size() < n && c < 3000) begin @(negedge clk); c++; end
    chk(nm, pix.size() >= n, 1'b1);
  endtask

  typedef struct {
    logic [8:0] y, x; logic [7:0] tile; logic [3:0] pal; bit fx, fy;
    logic [8:0] vpos; logic [23:0] data; int idx; bit ck_div; bit hit;
    logic [15:0] a0, a1; logic [8:0] f0, f1; logic [63:0] px;
  } vec_t;
  vec_t vecs[5];

  logic [63:0] g0, g1;
  int lat;
  logic [59:0] rst_vals;
  localparam logic [59:0] RST_EXP = {8'hFF, 9'd0, 1'b0, 1'b1, 1'b0, 16'h0, 6'h0, 1'b0, 16'h0};

  initial begin
    // y, x, tile, pal, fx, fy, vpos, data, idx, ck_div, hit, a0, a1, f0, f1, px
    vecs[0] = '{9'd100, 9'd40, 8'h05, 4'h3, 1'b0, 1'b0, 9'd105, 24'h0F3355, 0, 1'b0, 1'b1,
                16'h00AA, 16'h00AB, 9'd40, 9'd48, 64'h18191A1B1C1D1E1F};
    vecs[1] = '{9'd200, 9'd508, 8'hA7, 4'h9, 1'b0, 1'b0, 9'd200, 24'hFF0000, 63, 1'b1, 1'b1,
                16'h14E0, 16'h14E1, 9'd508, 9'd4, {8{8'h4C}}};
`ifdef ALPHAMISSION_SPR_FLIP_EN
    vecs[2] = '{9'd300, 9'd100, 8'h3C, 4'hF, 1'b1, 1'b1, 9'd302, 24'h0F3355, 17, 1'b0, 1'b1,
                16'h079A, 16'h079B, 9'd100, 9'd108, 64'h7F7E7D7C7B7A7978};
`else
    vecs[2] = '{9'd300, 9'd100, 8'h3C, 4'hF, 1'b1, 1'b1, 9'd302, 24'h0F3355, 17, 1'b0, 1'b1,
                16'h0784, 16'h0785, 9'd100, 9'd108, 64'h78797A7B7C7D7E7F};
`endif
    vecs[3] = '{9'd500, 9'd0, 8'hFF, 4'h0, 1'b0, 1'b0, 9'd3, 24'h00FF00, 5, 1'b1, 1'b1,
                16'h1FFE, 16'h1FFF, 9'd0, 9'd8, {8{8'h02}}};
    vecs[4] = '{9'd89, 9'd40, 8'h05, 4'h3, 1'b0, 1'b0, 9'd105, 24'h0F3355, 30, 1'b0, 1'b0,
                16'h0, 16'h0, 9'd0, 9'd0, 64'h0};
    fill_miss(9'd0);
    repeat (3) @(negedge clk);
    rst_vals = {FD, FL_Y, FCK, LD, GFX_REQ, GFX_ADDR, ATTR_ADDR, LINE_DONE, 16'h0};
    chk("reset_outputs", rst_vals, RST_EXP);
    VIDEO_RSTn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      fill_miss(vecs[i].vpos);
      mem[vecs[i].idx] = mk_attr(vecs[i].y, vecs[i].x, vecs[i].tile, vecs[i].fx, vecs[i].fy, vecs[i].pal);
      ck_div = vecs[i].ck_div;
      gfx_val = vecs[i].data;
      clear();
      start_line(vecs[i].vpos);
      wait_done(lat);
      chk($sformatf("v%0d_done", i), done_cnt, 1);
      chk($sformatf("v%0d_npix", i), pix.size(), vecs[i].hit ? 16 : 0);
      chk($sformatf("v%0d_nreq", i), addrs.size(), vecs[i].hit ? 2 : 0);
      chk($sformatf("v%0d_nfck", i), fck_cnt, vecs[i].hit ? 2 : 0);
      if (vecs[i].hit) begin
        g0 = '0; g1 = '0;
        for (int k = 0; k < 8; k++) begin
          g0 = {g0[55:0], k < pix.size() ? pix[k] : 8'hEE};
          g1 = {g1[55:0], k + 8 < pix.size() ? pix[k + 8] : 8'hEE};
        end
        chk($sformatf("v%0d_addr0", i), addrs.size() > 0 ? addrs[0] : 16'hDEAD, vecs[i].a0);
        chk($sformatf("v%0d_addr1", i), addrs.size() > 1 ? addrs[1] : 16'hDEAD, vecs[i].a1);
        chk($sformatf("v%0d_fly0", i), flys.size() > 0 ? flys[0] : 9'h1EE, vecs[i].f0);
        chk($sformatf("v%0d_fly1", i), flys.size() > 1 ? flys[1] : 9'h1EE, vecs[i].f1);
        chk($sformatf("v%0d_pix_h0", i), g0, vecs[i].px);
        chk($sformatf("v%0d_pix_h1", i), g1, vecs[i].px);
      end else chk($sformatf("v%0d_latency", i), lat, 193);
    end
    ck_div = 1'b0;

    // Slow ROM: request must sit still with no pixel slots consumed
    fill_miss(9'd105);
    mem[0] = mk_attr(9'd100, 9'd40, 8'h05, 1'b0, 1'b0, 4'h3);
    gfx_val = 24'h0F3355;
    ack_delay = 20;
    clear();
    start_line(9'd105);
    wait_done(lat);
    chk("slow_req_len", lens.size() > 0 ? lens[0] : 0, 21);
    chk("slow_addr_moves", addr_moves, 0);
    chk("slow_fck_in_wait", fck_wait, 0);
    chk("slow_npix", pix.size(), 16);
    ack_delay = 0;

    // Abort during the pixels of sprite 7
    fill_miss(9'd105);
    for (int k = 0; k < 8; k++) mem[k] = mk_attr(9'd100, 9'(k * 16), 8'(k), 1'b0, 1'b0, 4'h3);
    clear();
    start_line(9'd105);
    wait_pix(115, "abort_reach_spr7");
    LINE_START = 1'b1;
    @(negedge clk);
    LINE_START = 1'b0;
    chk("abort_attr_addr", ATTR_ADDR, 6'd0);
    chk("abort_no_done", done_cnt, 0);
    clear();
    wait_done(lat);
    chk("abort_done_once", done_cnt, 1);
    chk("abort_npix", pix.size(), 128);
    chk("abort_nreq", addrs.size(), 16);
    chk("abort_first_addr", addrs.size() > 0 ? addrs[0] : 16'hDEAD, 16'h000A);

    // Abort while waiting on the ROM
    fill_miss(9'd105);
    mem[3] = mk_attr(9'd100, 9'd40, 8'h05, 1'b0, 1'b0, 4'h3);
    ack_delay = 50;
    clear();
    start_line(9'd105);
    lat = 0;
    while (!GFX_REQ && lat < 200) begin @(negedge clk); lat++; end
    chk("fetch_abort_reach", GFX_REQ, 1'b1);
    repeat (5) @(negedge clk);
    LINE_START = 1'b1;
    @(negedge clk);
    LINE_START = 1'b0;
    chk("fetch_abort_req_drop", GFX_REQ, 1'b0);
    chk("fetch_abort_attr_addr", ATTR_ADDR, 6'd0);
    ack_delay = 0;
    wait_done(lat);
    chk("fetch_abort_done_once", done_cnt, 1);
    chk("fetch_abort_npix", pix.size(), 16);

    // Asynchronous reset in the middle of a line
    fill_miss(9'd105);
    mem[0] = mk_attr(9'd100, 9'd40, 8'h05, 1'b0, 1'b0, 4'h3);
    clear();
    start_line(9'd105);
    wait_pix(3, "midreset_reach");
    #2 VIDEO_RSTn = 1'b0;
    #1 rst_vals = {FD, FL_Y, FCK, LD, GFX_REQ, GFX_ADDR, ATTR_ADDR, LINE_DONE, 16'h0};
    chk("midreset_outputs", rst_vals, RST_EXP);
    repeat (2) @(negedge clk);
    VIDEO_RSTn = 1'b1;
    @(negedge clk);
    clear();
    repeat (300) @(negedge clk);
    chk("midreset_npix", pix.size(), 0);
    chk("midreset_nreq", addrs.size(), 0);
    chk("midreset_done", done_cnt, 0);
    chk("midreset_fck", fck_cnt, 0);

    chk("fd_idle_value", fd_bad, 0);
    chk("ld_vs_fck", ld_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
